// File: rtl/ps2_key_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl_pkg
// Shared definitions for the PS/2 keyboard sequencer:
//   - set-2 scancode constants used by the prefix parser and modifier tracker
//   - length of the E1 (pause) tail that is popped without decoding
//   - FSM state encoding
//   - helper that flags the two bytes a keyboard only sends on error
// ---------------------------------------------------------------------------
package ps2_key_ctrl_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_F0     = 8'hF0;  // break prefix
  localparam logic [7:0] SC_E1     = 8'hE1;  // pause sequence start
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // Bytes following E1; the pause sequence is always 8 bytes in total.
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  // 00 (key detection error / buffer overrun) and FF are never valid codes.
  function automatic logic is_bad_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl_if
// Bundles the sequencer's FIFO-side and consumer-side signals.
//   master : the sequencer (drives kb_rdn, ev_*, mods, err)
//   slave  : its environment (keyboard FIFO, CPU/console consumer)
// Signals:
//   kb_ready, kb_data[7:0], kb_overflow  FIFO status / head byte
//   kb_rdn                               active-low pop strobe
//   ev_valid, ev_ack                     event handshake
//   ev_code[7:0], ev_ext, ev_brk         event payload
//   mods[3:0]                            {alt, ctrl, rshift, lshift}
//   err[2:0], err_clr                    sticky {bad_byte, timeout, overflow}
// ---------------------------------------------------------------------------
interface ps2_key_ctrl_if;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_overflow;
  logic       kb_rdn;
  logic       ev_valid;
  logic       ev_ack;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [3:0] mods;
  logic [2:0] err;
  logic       err_clr;

  modport master (
    input  kb_ready, kb_data, kb_overflow, ev_ack, err_clr,
    output kb_rdn, ev_valid, ev_code, ev_ext, ev_brk, mods, err
  );

  modport slave (
    output kb_ready, kb_data, kb_overflow, ev_ack, err_clr,
    input  kb_rdn, ev_valid, ev_code, ev_ext, ev_brk, mods, err
  );
endinterface

// File: rtl/ps2_key_ctrl_prefix_timer.sv
// ---------------------------------------------------------------------------
// ps2_prefix_timer
// Watchdog for a dangling E0/F0 prefix. Counts cycles while 'run' is high;
// 'expired' pulses for one cycle on the TIMEOUT-th counted cycle and the
// counter wraps to zero. 'restart' zeroes the count.
// Ports:
//   clk      in  system clock
//   clr      in  asynchronous active-high reset
//   run      in  count enable
//   restart  in  synchronous clear
//   expired  out one-cycle pulse when TIMEOUT cycles have been counted
// ---------------------------------------------------------------------------
module ps2_prefix_timer #(
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  input  logic restart,
  output logic expired
);

  logic [TW-1:0] r_cnt;
  logic          w_hit;

  // Decoded from the registered count so the pulse lands in the same cycle
  // the count wraps, letting the parent clear its flags on that edge.
  assign w_hit   = run && (r_cnt == TW'(TIMEOUT - 1));
  assign expired = w_hit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                     r_cnt <= '0;
    else if (restart || w_hit)   r_cnt <= '0;
    else if (run)                r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
// Pops set-2 scancode bytes from the keyboard FIFO, strips E0/F0/E1
// prefixes and presents one key event per complete code, while tracking
// modifier keys and sticky error conditions.
// Ports:
//   clk   in   system clock
//   clr   in   asynchronous active-high reset
//   bus   ps2_key_ctrl_if.master (FIFO handshake, event handshake, mods, err)
// Flow: IDLE -> POP -> DECODE -> IDLE per byte; E1 diverts to SKIP, which
// pops the 7 trailing pause bytes undecoded and then emits a single E1 event.
// ---------------------------------------------------------------------------
module ps2_key_ctrl
  import ps2_key_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic           clk,
  input  logic           clr,
  ps2_key_ctrl_if.master bus
);

  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_kb_rdn;
  logic       r_ev_valid;
  logic [7:0] r_ev_code;
  logic       r_ev_ext;
  logic       r_ev_brk;
  logic [3:0] r_mods;
  logic [2:0] r_err;
  logic       r_ext_f;
  logic       r_brk_f;
  logic [2:0] r_skip_cnt;
  logic       r_in_skip;   // POP returns to SKIP instead of DECODE

  logic       w_run;
  logic       w_restart;
  logic       w_expired;
  logic       w_bad;
  logic       w_fake;
  logic [2:0] w_err_set;

  // Timer only advances while a prefix waits for a byte that has not arrived;
  // a byte stuck behind an unacknowledged event (kb_ready=1) freezes it.
  assign w_run     = (r_ext_f || r_brk_f) && (r_state == ST_IDLE) && !bus.kb_ready;
  assign w_restart = (r_state == ST_DECODE);
  assign w_bad     = (r_state == ST_DECODE) && is_bad_byte(r_byte);
  // E0-12 / E0-59 are shift wrappers the keyboard adds around some E0 keys.
  assign w_fake    = r_ext_f && ((r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT));
  assign w_err_set = {w_bad, w_expired, bus.kb_overflow};

  ps2_prefix_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk     (clk),
    .clr     (clr),
    .run     (w_run),
    .restart (w_restart),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_kb_rdn   <= 1'b1;
      r_ev_valid <= 1'b0;
      r_ev_code  <= '0;
      r_ev_ext   <= 1'b0;
      r_ev_brk   <= 1'b0;
      r_mods     <= '0;
      r_ext_f    <= 1'b0;
      r_brk_f    <= 1'b0;
      r_skip_cnt <= '0;
      r_in_skip  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so later assignments in this block
      // (e.g. a new event) override the ack clear without ordering hazards.
      if (r_ev_valid && bus.ev_ack) r_ev_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_expired) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
          end
          if (bus.kb_ready && !r_ev_valid) begin
            r_byte   <= bus.kb_data;
            r_kb_rdn <= 1'b0;
            r_state  <= ST_POP;
          end
        end

        ST_POP: begin
          r_kb_rdn <= 1'b1;
          r_state  <= r_in_skip ? ST_SKIP : ST_DECODE;
        end

        ST_DECODE: begin
          r_state <= ST_IDLE;
          if (r_byte == SC_E0) begin
            r_ext_f <= 1'b1;
          end else if (r_byte == SC_F0) begin
            r_brk_f <= 1'b1;
          end else begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
            if (r_byte == SC_E1) begin
              r_skip_cnt <= E1_SKIP_LEN;
              r_in_skip  <= 1'b1;
              r_state    <= ST_SKIP;
            end else if (!is_bad_byte(r_byte) && !w_fake) begin
              r_ev_valid <= 1'b1;
              r_ev_code  <= r_byte;
              r_ev_ext   <= r_ext_f;
              r_ev_brk   <= r_brk_f;
              case (r_byte)
                SC_LSHIFT: r_mods[0] <= !r_brk_f;
                SC_RSHIFT: r_mods[1] <= !r_brk_f;
                SC_CTRL:   r_mods[2] <= !r_brk_f;
                SC_ALT:    r_mods[3] <= !r_brk_f;
                default:   ;
              endcase
            end
          end
        end

        ST_SKIP: begin
          if (r_skip_cnt == 3'd0) begin
            r_ev_valid <= 1'b1;
            r_ev_code  <= SC_E1;
            r_ev_ext   <= 1'b0;
            r_ev_brk   <= 1'b0;
            r_in_skip  <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (bus.kb_ready && !r_ev_valid) begin
            r_kb_rdn   <= 1'b0;
            r_skip_cnt <= r_skip_cnt - 1'b1;
            r_state    <= ST_POP;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Set wins over clear on a per-bit basis.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_err <= '0;
    else     r_err <= (bus.err_clr ? 3'b000 : r_err) | w_err_set;
  end

  assign bus.kb_rdn   = r_kb_rdn;
  assign bus.ev_valid = r_ev_valid;
  assign bus.ev_code  = r_ev_code;
  assign bus.ev_ext   = r_ev_ext;
  assign bus.ev_brk   = r_ev_brk;
  assign bus.mods     = r_mods;
  assign bus.err      = r_err;

endmodule
